// File: rtl/task3_pkg.sv
// Shared types and constants for the circle demo: top FSM states,
// circle engine states, screen geometry and colours.
package task3_pkg;

    localparam int unsigned SCREEN_W = 160;
    localparam int unsigned SCREEN_H = 120;
    localparam int unsigned COORD_W  = 10;

    localparam logic [2:0] COLOUR_BLACK = 3'b000;
    localparam logic [2:0] COLOUR_GREEN = 3'b010;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        CIRCLE = 2'd1,
        DONE   = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        C_IDLE = 2'd0,
        C_DRAW = 2'd1,
        C_DONE = 2'd2
    } circle_state_e;

endpackage

// File: rtl/circle_drawer.sv
// Midpoint circle engine: eight octant points per step, one per cycle,
// off-screen points keep their slot but are not plotted.
module circle_drawer
    import task3_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] cx,
    input  logic [6:0] cy,
    input  logic [7:0] radius,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic       plot,
    output logic       done
);

    localparam logic signed [COORD_W-1:0] SCR_W = COORD_W'(SCREEN_W);
    localparam logic signed [COORD_W-1:0] SCR_H = COORD_W'(SCREEN_H);
    localparam logic signed [COORD_W-1:0] ONE   = COORD_W'(1);

    circle_state_e               state_q, state_d;
    logic signed [COORD_W-1:0]   ox_q, ox_d, oy_q, oy_d, crit_q, crit_d;
    logic [2:0]                  idx_q, idx_d;
    logic signed [COORD_W-1:0]   cx_s, cy_s, r_s, px, py, oy_n, ox_n;
    logic                        in_range;

    assign cx_s = $signed({2'b00, cx});
    assign cy_s = $signed({3'b000, cy});
    assign r_s  = $signed({2'b00, radius});

    // Select the current octant point and check it against the screen
    always_comb begin
        px = cx_s;
        py = cy_s;
        case (idx_q)
            3'd0: begin px = cx_s + oy_q; py = cy_s + ox_q; end
            3'd1: begin px = cx_s + ox_q; py = cy_s + oy_q; end
            3'd2: begin px = cx_s - oy_q; py = cy_s + ox_q; end
            3'd3: begin px = cx_s - ox_q; py = cy_s + oy_q; end
            3'd4: begin px = cx_s - ox_q; py = cy_s - oy_q; end
            3'd5: begin px = cx_s - oy_q; py = cy_s - ox_q; end
            3'd6: begin px = cx_s + ox_q; py = cy_s - oy_q; end
            default: begin px = cx_s + oy_q; py = cy_s - ox_q; end
        endcase
        in_range = (px >= 0) && (px < SCR_W) && (py >= 0) && (py < SCR_H);
        vga_x = px[7:0];
        vga_y = py[6:0];
    end

    // Next-state, octant stepping and midpoint error update
    always_comb begin
        state_d = state_q;
        ox_d    = ox_q;
        oy_d    = oy_q;
        crit_d  = crit_q;
        idx_d   = idx_q;
        plot    = 1'b0;
        done    = 1'b0;
        oy_n    = oy_q + ONE;
        ox_n    = ox_q - ONE;
        case (state_q)
            C_IDLE: begin
                if (start) begin
                    oy_d    = '0;
                    ox_d    = r_s;
                    crit_d  = ONE - r_s;
                    idx_d   = '0;
                    state_d = C_DRAW;
                end
            end
            C_DRAW: begin
                if (!start) begin
                    state_d = C_IDLE;
                end else if (oy_q > ox_q) begin
                    done    = 1'b1;
                    state_d = C_DONE;
                end else begin
                    plot  = in_range;
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        oy_d = oy_n;
                        if (crit_q <= 0) begin
                            crit_d = crit_q + (oy_n <<< 1) + ONE;
                        end else begin
                            ox_d   = ox_n;
                            crit_d = crit_q + ((oy_n - ox_n) <<< 1) + ONE;
                        end
                    end
                end
            end
            C_DONE: begin
                done = 1'b1;
                if (!start) state_d = C_IDLE;
            end
            default: state_d = C_IDLE;
        endcase
    end

    // Engine state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= C_IDLE;
            ox_q    <= '0;
            oy_q    <= '0;
            crit_q  <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            ox_q    <= ox_d;
            oy_q    <= oy_d;
            crit_q  <= crit_d;
            idx_q   <= idx_d;
        end
    end

endmodule

// File: rtl/task3_circle_top.sv
// Demo top: clears the 160x120 screen, draws one circle, then idles.
module task3_circle_top
    import task3_pkg::*;
#(
    parameter int unsigned CENTRE_X      = 80,
    parameter int unsigned CENTRE_Y      = 60,
    parameter int unsigned RADIUS        = 40,
    parameter logic [2:0]  CIRCLE_COLOUR = COLOUR_GREEN,
    parameter logic [2:0]  FILL_COLOUR   = COLOUR_BLACK
) (
    input  logic       CLOCK_50,
    input  logic [3:0] KEY,
    output logic [7:0] VGA_X,
    output logic [6:0] VGA_Y,
    output logic [2:0] VGA_COLOUR,
    output logic       VGA_PLOT
);

    logic   rst_n;
    logic   unused_keys;
    state_e state, state_q, state_d;
    logic   start_fillScreen, start_circle, done_fillScreen, done_circle;

    logic [7:0] fill_x_q, fill_x_d;
    logic [6:0] fill_y_q, fill_y_d;
    logic       fill_done_q, fill_done_d, fill_plot;

    logic [7:0] circ_x;
    logic [6:0] circ_y;
    logic       circ_plot;

    logic [7:0] vga_x_q, vga_x_d;
    logic [6:0] vga_y_q, vga_y_d;
    logic [2:0] vga_colour_q, vga_colour_d;
    logic       vga_plot_q, vga_plot_d;

    assign rst_n       = KEY[3];
    assign unused_keys = &{1'b0, KEY[2:0]};

    assign state            = state_q;
    assign start_fillScreen = (state_q == FILL);
    assign start_circle     = (state_q == CIRCLE);
    assign done_fillScreen  = fill_done_q;

    // Top FSM next-state
    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL:    if (done_fillScreen) state_d = CIRCLE;
            CIRCLE:  if (done_circle) state_d = DONE;
            DONE:    state_d = DONE;
            default: state_d = FILL;
        endcase
    end

    // Fill scan: y inner, x outer; done holds until start drops
    always_comb begin
        fill_x_d    = fill_x_q;
        fill_y_d    = fill_y_q;
        fill_done_d = fill_done_q;
        fill_plot   = 1'b0;
        if (!start_fillScreen) begin
            fill_x_d    = '0;
            fill_y_d    = '0;
            fill_done_d = 1'b0;
        end else if (!fill_done_q) begin
            fill_plot = 1'b1;
            if (fill_y_q == 7'(SCREEN_H - 1)) begin
                fill_y_d = '0;
                if (fill_x_q == 8'(SCREEN_W - 1)) begin
                    fill_x_d    = '0;
                    fill_done_d = 1'b1;
                end else begin
                    fill_x_d = fill_x_q + 8'd1;
                end
            end else begin
                fill_y_d = fill_y_q + 7'd1;
            end
        end
    end

    circle_drawer u_circle (
        .clk    (CLOCK_50),
        .rst_n  (rst_n),
        .start  (start_circle),
        .cx     (8'(CENTRE_X)),
        .cy     (7'(CENTRE_Y)),
        .radius (8'(RADIUS)),
        .vga_x  (circ_x),
        .vga_y  (circ_y),
        .plot   (circ_plot),
        .done   (done_circle)
    );

    // Output mux from whichever engine the FSM has enabled
    always_comb begin
        vga_x_d      = '0;
        vga_y_d      = '0;
        vga_colour_d = FILL_COLOUR;
        vga_plot_d   = 1'b0;
        case (state_q)
            FILL: begin
                vga_x_d    = fill_x_q;
                vga_y_d    = fill_y_q;
                vga_plot_d = fill_plot;
            end
            CIRCLE: begin
                vga_x_d      = circ_x;
                vga_y_d      = circ_y;
                vga_colour_d = CIRCLE_COLOUR;
                vga_plot_d   = circ_plot;
            end
            default: ;
        endcase
    end

    // State, fill counters and registered VGA outputs
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= FILL;
            fill_x_q     <= '0;
            fill_y_q     <= '0;
            fill_done_q  <= 1'b0;
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_colour_q <= '0;
            vga_plot_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            fill_x_q     <= fill_x_d;
            fill_y_q     <= fill_y_d;
            fill_done_q  <= fill_done_d;
            vga_x_q      <= vga_x_d;
            vga_y_q      <= vga_y_d;
            vga_colour_q <= vga_colour_d;
            vga_plot_q   <= vga_plot_d;
        end
    end

    assign VGA_X      = vga_x_q;
    assign VGA_Y      = vga_y_q;
    assign VGA_COLOUR = vga_colour_q;
    assign VGA_PLOT   = vga_plot_q;

endmodule

// File: tb/tb_task3_circle_top.sv
// Scoreboard bench for the circle demo top.
module tb_task3_circle_top;

    logic       clk = 1'b0;
    logic [3:0] KEY = 4'b0111;
    logic [7:0] VGA_X;
    logic [6:0] VGA_Y;
    logic [2:0] VGA_COLOUR;
    logic       VGA_PLOT;

    logic [17:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int plot_cnt = 0;
    int n_circle = 0;

    task3_circle_top dut (
        .CLOCK_50   (clk),
        .KEY        (KEY),
        .VGA_X      (VGA_X),
        .VGA_Y      (VGA_Y),
        .VGA_COLOUR (VGA_COLOUR),
        .VGA_PLOT   (VGA_PLOT)
    );

    always #5 clk = ~clk;

    // Monitor: every plotted pixel must match the head of the queue
    always @(negedge clk) begin
        if (VGA_PLOT) begin
            logic [17:0] e;
            plot_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pixel_unexpected: got (%0d,%0d,c%0d), queue empty",
                         VGA_X, VGA_Y, VGA_COLOUR);
            end else begin
                e = exp_q.pop_front();
                if ({VGA_X, VGA_Y, VGA_COLOUR} !== e) begin
                    errors++;
                    $display("FAIL pixel: got (%0d,%0d,c%0d), expected (%0d,%0d,c%0d)",
                             VGA_X, VGA_Y, VGA_COLOUR, e[17:10], e[9:3], e[2:0]);
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    task automatic push_fill();
        for (int x = 0; x < 160; x++)
            for (int y = 0; y < 120; y++)
                exp_q.push_back({8'(x), 7'(y), 3'b000});
    endtask

    task automatic push_pt(input int x, input int y);
        if (x >= 0 && x < 160 && y >= 0 && y < 120)
            exp_q.push_back({8'(x), 7'(y), 3'b010});
    endtask

    // Reference midpoint circle, centre (80,60), r=40
    task automatic push_circle(output int n);
        int ox, oy, crit;
        int cx = 80, cy = 60;
        n = 0; oy = 0; ox = 40; crit = 1 - 40;
        while (oy <= ox) begin
            push_pt(cx + oy, cy + ox); push_pt(cx + ox, cy + oy);
            push_pt(cx - oy, cy + ox); push_pt(cx - ox, cy + oy);
            push_pt(cx - ox, cy - oy); push_pt(cx - oy, cy - ox);
            push_pt(cx + ox, cy - oy); push_pt(cx + oy, cy - ox);
            n += 8;
            oy++;
            if (crit <= 0) crit += 2 * oy + 1;
            else begin ox--; crit += 2 * (oy - ox) + 1; end
        end
    endtask

    task automatic wait_state(input int s, input int limit, input string name);
        int i;
        for (i = 0; i < limit; i++) begin
            @(posedge clk); #1;
            if (int'(dut.state) == s) break;
        end
        if (i == limit) begin
            checks++; errors++;
            $display("FAIL %s: timeout waiting for state %0d, state is %0d",
                     name, s, int'(dut.state));
        end
    endtask

    initial begin
        int cnt;
        push_fill();
        push_circle(n_circle);
        repeat (2) @(posedge clk);
        @(negedge clk) KEY[3] = 1'b1;
        #1;
        check("rst_state", int'(dut.state), 0);
        check("rst_start_fill", int'(dut.start_fillScreen), 1);
        check("rst_start_circle", int'(dut.start_circle), 0);
        check("rst_x", int'(VGA_X), 0);
        check("rst_y", int'(VGA_Y), 0);
        check("rst_plot", int'(VGA_PLOT), 0);
        @(posedge clk); #1;
        check("first_plot", int'(VGA_PLOT), 1);
        check("first_xy", int'({VGA_X, VGA_Y}), 0);

        wait_state(1, 19300, "to_circle");
        check("fill_done", int'(dut.done_fillScreen), 1);
        check("circ_start", int'(dut.start_circle), 1);
        check("circ_fill_off", int'(dut.start_fillScreen), 0);
        check("circ_entry_plot", int'(VGA_PLOT), 0);
        check("fill_consumed", exp_q.size(), n_circle);
        check("fill_plot_count", plot_cnt, 19200);
        repeat (2) @(posedge clk); #1;
        check("fill_done_drop", int'(dut.done_fillScreen), 0);
        check("circ_first_plot", int'(VGA_PLOT), 1);
        check("circ_first_x", int'(VGA_X), 80);
        check("circ_first_y", int'(VGA_Y), 100);
        check("circ_colour", int'(VGA_COLOUR), 2);

        wait_state(2, 1000, "to_done");
        check("done_start_fill", int'(dut.start_fillScreen), 0);
        check("done_start_circle", int'(dut.start_circle), 0);
        check("done_plot", int'(VGA_PLOT), 0);
        check("circle_consumed", exp_q.size(), 0);
        check("total_plots", plot_cnt, 19200 + n_circle);
        cnt = 0;
        repeat (19200) begin
            @(negedge clk);
            if (VGA_PLOT) cnt++;
        end
        check("done_idle_plots", cnt, 0);

        // Second run, aborted part way through the circle
        @(negedge clk) KEY[3] = 1'b0;
        exp_q.delete();
        push_fill();
        push_circle(n_circle);
        @(negedge clk) KEY[3] = 1'b1;
        wait_state(1, 19300, "rerun_to_circle");
        repeat (100) @(posedge clk);
        #1 KEY[3] = 1'b0;
        #1;
        check("abort_state", int'(dut.state), 0);
        check("abort_start_fill", int'(dut.start_fillScreen), 1);
        check("abort_plot", int'(VGA_PLOT), 0);
        check("abort_xy", int'({VGA_X, VGA_Y}), 0);
        exp_q.delete();
        push_fill();
        @(negedge clk) KEY[3] = 1'b1;
        @(posedge clk); #1;
        check("restart_plot", int'(VGA_PLOT), 1);
        check("restart_xy", int'({VGA_X, VGA_Y}), 0);
        wait_state(1, 19300, "restart_to_circle");
        check("restart_fill_consumed", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/task3_circle_top.md
Name: task3_circle_top

Overview:
- Top-level demo for the 160x120 VGA adapter.
- After reset it clears the whole screen to black, pixel by pixel, then draws one green circle (centre (80,60), radius 40) using the midpoint (Bresenham) algorithm, then stops.
- Pixel writes go out on the VGA_X/VGA_Y/VGA_COLOUR/VGA_PLOT interface.
- The VGA adapter itself is outside this block.

Parameters:
- CENTRE_X, 80, circle centre x.
- CENTRE_Y, 60, circle centre y.
- RADIUS, 40, circle radius.
- CIRCLE_COLOUR, 3'b010, circle colour (green).
- FILL_COLOUR, 3'b000, clear colour (black).

Ports:
- CLOCK_50  in  1  system clock, all logic on the rising edge.
- KEY  in  4  KEY[3] is the reset: asynchronous, active-low. KEY[2:0] are unused.
- VGA_X  out  8  pixel x, 0..159.
- VGA_Y  out  7  pixel y, 0..119.
- VGA_COLOUR  out  3  pixel colour.
- VGA_PLOT  out  1  write strobe: one pixel is written per cycle while high.

Behaviour:
- Reset (KEY[3]=0):
  - state=FILL (encoding 0), start_fillScreen=1, start_circle=0.
  - VGA_X=0, VGA_Y=0, VGA_PLOT=0, all counters cleared.
- Top FSM, 2-bit state register:
  - FILL=0, CIRCLE=1, DONE=2.
  - FILL: start_fillScreen=1. When done_fillScreen=1, go to CIRCLE.
  - CIRCLE: start_circle=1, start_fillScreen=0. When done_circle=1, go to DONE.
  - DONE: both starts are 0 and VGA_PLOT=0. Stay here until reset.
- Fill engine:
  - Plotting starts the first clock edge after reset release.
  - Scan order: x outer 0..159, y inner 0..119.
  - One pixel per cycle, VGA_PLOT=1, colour FILL_COLOUR.
  - First pixel is (0,0); 19200 plotting cycles in total.
  - After pixel (159,119), done_fillScreen is held at 1 and VGA_PLOT=0 for as long as start_fillScreen stays high.
  - done_fillScreen drops to 0 one cycle after start_fillScreen goes low.
- Circle engine:
  - Init on start: oy=0, ox=RADIUS, crit=1-RADIUS. Use signed arithmetic, width at least 9 bits.
  - While oy<=ox, plot 8 points, one per cycle, in this order:
    - (cx+oy, cy+ox), (cx+ox, cy+oy)
    - (cx-oy, cy+ox), (cx-ox, cy+oy)
    - (cx-ox, cy-oy), (cx-oy, cy-ox)
    - (cx+ox, cy-oy), (cx+oy, cy-ox)
  - After the 8 points: oy=oy+1. If crit<=0, crit+=2*oy+1; otherwise ox=ox-1 and crit+=2*(oy-ox)+1 (new values).
  - First plotted pixel is (80,100), two cycles after the FSM enters CIRCLE.
  - Clipping: any point with x outside 0..159 or y outside 0..119 is not plotted (VGA_PLOT=0 that cycle), but still takes its slot.
  - When oy>ox: done_circle=1 and VGA_PLOT=0.
- Outputs come from a mux of the active engine and are registered. VGA_PLOT is never 1 in DONE or during FSM transition cycles.
- Reset mid-operation aborts immediately and restarts from FILL.

Decomposition:
- Package task3_pkg: state enum (FILL, CIRCLE, DONE), screen size constants (160, 120), colour constants.
- Sub-module circle_drawer: start/done handshake, centre and radius inputs, outputs vga_x/vga_y/plot.
- The fill engine and the top FSM stay in the top module.
- Internal nets state, start_fillScreen, start_circle, done_fillScreen must keep these names; the bench probes them hierarchically.

Test Plan:
- Hold KEY[3]=0 for 2 cycles, then release -> first cycle: state=0, start_fillScreen=1, start_circle=0, X=0, Y=0, PLOT=0. Next cycle: PLOT=1 with (0,0).
- Run 19200 cycles -> every (x,y) is plotted exactly once with colour 0, in x-outer order. Then state=1, done_fillScreen=1, start_circle=1, PLOT=0.
- Two cycles after entering CIRCLE -> done_fillScreen=0, PLOT=1, X=80, Y=100, colour 3'b010.
- Circle run -> points match the software midpoint model for r=40, including (108,89). About 232 plotting cycles, then state=2, both starts 0, PLOT=0.
- In DONE, wait 19200 cycles -> PLOT stays 0.
- Assert KEY[3]=0 in the middle of the circle -> outputs return to reset values at once, and the fill restarts from (0,0).
